// File: rtl/game_pkg.sv
// Shared types and constants for the game input front end.
// Imported by the interface, the debouncer and the top-level controller.
package game_pkg;

    typedef enum logic [1:0] {
        K_IDLE   = 2'd0,
        K_HELD   = 2'd1,
        K_REPEAT = 2'd2
    } key_state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int width_for(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// Event bundle from the input front end to the game-state FSM.
// The front end drives it through the master modport; the game FSM reads it through the slave modport.
interface game_input_ctrl_if;
    import game_pkg::*;

    logic [7:0]  keycode;
    logic        key_valid;
    logic        key_release;
    logic        key_held;
    logic        button_press;
    logic        button_level;
    logic [31:0] debugging;

    modport master (
        output keycode, key_valid, key_release, key_held,
        output button_press, button_level, debugging
    );

    modport slave (
        input keycode, key_valid, key_release, key_held,
        input button_press, button_level, debugging
    );

endinterface

// File: rtl/game_input_ctrl_debounce_sync.sv
// Two-flop synchroniser plus stable-time debouncer for one asynchronous board button.
// Produces the debounced level and a one-cycle pulse the cycle after that level rises.
module debounce_sync
    import game_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = width_for(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             rise_r;

    // Synchronise the pin, count consecutive disagreeing cycles and flip the level once stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync1_r   <= din;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            rise_r    <= level_r & ~level_d_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/game_input_ctrl.sv
// Keyboard/button front end: turns the held HID keycode and raw push-button into clean
// one-cycle press/change/repeat/release strobes and a debounced button pulse.
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        keycode_in,
    input  logic              button_raw,
    game_input_ctrl_if.master game
);

    localparam int                 TIMER_W    = width_for(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [TIMER_W-1:0] TIMER_SAT  = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(REPEAT_RATE - 1);
    localparam logic               REPEAT_EN  = (REPEAT_DELAY != 0);

    logic [7:0]         kin_r;
    key_state_t         state_r;
    key_state_t         state_s;
    logic [7:0]         keycode_r;
    logic [7:0]         keycode_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [TIMER_W-1:0] timer_inc_s;
    logic               key_valid_r;
    logic               key_valid_s;
    logic               key_release_r;
    logic               key_release_s;
    logic               key_held_r;
    logic               key_held_s;
    logic               button_level_s;
    logic               button_press_s;

    debounce_sync #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .clk   (clk),
        .reset (reset),
        .din   (button_raw),
        .level (button_level_s),
        .rise  (button_press_s)
    );

    // Saturating increment: the hold timer must never wrap back into a repeat window.
    always_comb begin
        if (timer_r == TIMER_SAT) begin
            timer_inc_s = timer_r;
        end else begin
            timer_inc_s = timer_r + TIMER_W'(1);
        end
    end

    // Key FSM next state and strobes; release beats change, change beats timer expiry.
    always_comb begin
        state_s       = state_r;
        keycode_s     = keycode_r;
        timer_s       = timer_inc_s;
        key_valid_s   = 1'b0;
        key_release_s = 1'b0;
        key_held_s    = key_held_r;
        case (state_r)
            K_IDLE: begin
                timer_s = {TIMER_W{1'b0}};
                if (kin_r != KEY_NONE) begin
                    keycode_s   = kin_r;
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                    state_s     = K_HELD;
                end else begin
                    key_held_s = 1'b0;
                end
            end
            K_HELD, K_REPEAT: begin
                if (kin_r == KEY_NONE) begin
                    key_release_s = 1'b1;
                    key_held_s    = 1'b0;
                    timer_s       = {TIMER_W{1'b0}};
                    state_s       = K_IDLE;
                end else if (kin_r != keycode_r) begin
                    keycode_s   = kin_r;
                    key_valid_s = 1'b1;
                    timer_s     = {TIMER_W{1'b0}};
                    state_s     = K_HELD;
                end else if ((state_r == K_HELD) && REPEAT_EN && (timer_r == DELAY_LAST)) begin
                    key_valid_s = 1'b1;
                    timer_s     = {TIMER_W{1'b0}};
                    state_s     = K_REPEAT;
                end else if ((state_r == K_REPEAT) && (timer_r == RATE_LAST)) begin
                    key_valid_s = 1'b1;
                    timer_s     = {TIMER_W{1'b0}};
                end else begin
                    timer_s = timer_inc_s;
                end
            end
            default: begin
                state_s    = K_IDLE;
                timer_s    = {TIMER_W{1'b0}};
                key_held_s = 1'b0;
            end
        endcase
    end

    // Input capture, FSM state and registered key outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            kin_r         <= KEY_NONE;
            state_r       <= K_IDLE;
            keycode_r     <= 8'h00;
            timer_r       <= {TIMER_W{1'b0}};
            key_valid_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_held_r    <= 1'b0;
        end else begin
            kin_r         <= keycode_in;
            state_r       <= state_s;
            keycode_r     <= keycode_s;
            timer_r       <= timer_s;
            key_valid_r   <= key_valid_s;
            key_release_r <= key_release_s;
            key_held_r    <= key_held_s;
        end
    end

    assign game.keycode      = keycode_r;
    assign game.key_valid    = key_valid_r;
    assign game.key_release  = key_release_r;
    assign game.key_held     = key_held_r;
    assign game.button_press = button_press_s;
    assign game.button_level = button_level_s;
    assign game.debugging    = {21'd0, button_level_s, keycode_r, state_r};

endmodule
